// File: rtl/axi_pkg.sv
// Shared AXI definitions: arbiter FSM encoding, burst/response codes, write-strobe helper.
// Pure declarations; no latency or backpressure of its own.
package axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    // Narrow strobes apply to single-beat accesses only; any burst writes full words.
    function automatic logic [3:0] size_to_wstrb(input logic [1:0] size,
                                                 input logic [1:0] addr_lo,
                                                 input logic       multi_beat);
        logic [3:0] strb;
        if (multi_beat || size >= 2'd2) begin
            strb = 4'b1111;
        end else if (size == 2'd1) begin
            strb = 4'b0011 << {addr_lo[1], 1'b0};
        end else begin
            strb = 4'b0001 << addr_lo;
        end
        return strb;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester at or after ptr wins, one-hot grant.
// Purely combinational, zero latency; no backpressure.
module rr_arbiter
    import axi_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_nport_arbiter.sv
// N sram-like ports onto one AXI3 master, one transaction in flight; grant one cycle after request.
// AXI valids come from state only; R/B/ready responses reach the ports combinationally.
module axi_nport_arbiter
    import axi_pkg::*;
#(
    parameter int N_PORTS = 3,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_PORTS-1:0]       p_req,
    input  logic [N_PORTS-1:0]       p_wr,
    input  logic [2*N_PORTS-1:0]     p_size,
    input  logic [ADDR_W*N_PORTS-1:0] p_addr,
    input  logic [LEN_W*N_PORTS-1:0] p_len,
    input  logic [32*N_PORTS-1:0]    p_wdata,
    output logic [31:0]              p_rdata,
    output logic [N_PORTS-1:0]       p_addr_ok,
    output logic [N_PORTS-1:0]       p_data_ok,
    output logic [N_PORTS-1:0]       p_wnext,
    output logic [3:0]               arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic [1:0]               arlock,
    output logic [3:0]               arcache,
    output logic [2:0]               arprot,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [3:0]               awid,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic [1:0]               awburst,
    output logic [1:0]               awlock,
    output logic [3:0]               awcache,
    output logic [2:0]               awprot,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [3:0]               wid,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic [3:0]               bid,
    input  logic [1:0]               bresp,
    input  logic                     bvalid,
    output logic                     bready
);

    localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    state_t              state, state_nx;
    logic [PW-1:0]       ptr, ptr_nx, gnt_idx, win_idx;
    logic [N_PORTS-1:0]  win_oh;
    logic [ADDR_W-1:0]   lat_addr;
    logic [1:0]          lat_size;
    logic [LEN_W-1:0]    lat_len, beat_cnt;
    logic                last_beat;
    logic                unused_axi;

    logic [ADDR_W-1:0]   addr_arr [N_PORTS];
    logic [1:0]          size_arr [N_PORTS];
    logic [LEN_W-1:0]    len_arr  [N_PORTS];
    logic [31:0]         wd_arr   [N_PORTS];

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
        assign addr_arr[gi] = p_addr[gi*ADDR_W +: ADDR_W];
        assign size_arr[gi] = p_size[gi*2 +: 2];
        assign len_arr[gi]  = p_len[gi*LEN_W +: LEN_W];
        assign wd_arr[gi]   = p_wdata[gi*32 +: 32];
    end

    rr_arbiter #(.N(N_PORTS), .PW(PW)) u_rr (
        .req   (p_req),
        .ptr   (ptr),
        .grant (win_oh)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (win_oh[i]) win_idx = PW'(i);
        end
    end

    assign ptr_nx    = (gnt_idx == PW'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    assign last_beat = (beat_cnt == lat_len);

    assign arid    = 4'(gnt_idx);
    assign araddr  = lat_addr;
    assign arlen   = 8'(lat_len);
    assign arsize  = {1'b0, lat_size};
    assign arburst = BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awid    = 4'(gnt_idx);
    assign awaddr  = lat_addr;
    assign awlen   = 8'(lat_len);
    assign awsize  = {1'b0, lat_size};
    assign awburst = BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = 4'(gnt_idx);

    // Response ids and codes are intentionally ignored.
    assign unused_axi = ^{rid, rresp, bid, bresp};

    always_comb begin
        state_nx  = state;
        arvalid   = 1'b0;
        awvalid   = 1'b0;
        rready    = 1'b0;
        wvalid    = 1'b0;
        wlast     = 1'b0;
        bready    = 1'b0;
        wdata     = '0;
        wstrb     = '0;
        p_rdata   = '0;
        p_addr_ok = '0;
        p_data_ok = '0;
        p_wnext   = '0;
        case (state)
            S_IDLE: begin
                if (|p_req) state_nx = p_wr[win_idx] ? S_AW : S_AR;
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    p_addr_ok[gnt_idx] = 1'b1;
                    state_nx           = S_R;
                end
            end
            S_R: begin
                rready  = 1'b1;
                p_rdata = rdata;
                if (rvalid) begin
                    p_data_ok[gnt_idx] = 1'b1;
                    if (rlast) state_nx = S_IDLE;
                end
            end
            S_AW: begin
                awvalid = 1'b1;
                if (awready) begin
                    p_addr_ok[gnt_idx] = 1'b1;
                    state_nx           = S_W;
                end
            end
            S_W: begin
                wvalid = 1'b1;
                wlast  = last_beat;
                wdata  = wd_arr[gnt_idx];
                wstrb  = size_to_wstrb(lat_size, lat_addr[1:0], lat_len != '0);
                if (wready) begin
                    if (last_beat) state_nx = S_B;
                    else           p_wnext[gnt_idx] = 1'b1;
                end
            end
            S_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    p_data_ok[gnt_idx] = 1'b1;
                    state_nx           = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ptr      <= '0;
            gnt_idx  <= '0;
            lat_addr <= '0;
            lat_size <= '0;
            lat_len  <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && |p_req) begin
                gnt_idx  <= win_idx;
                lat_addr <= addr_arr[win_idx];
                lat_size <= size_arr[win_idx];
                lat_len  <= len_arr[win_idx];
            end
            // Counter stops at len, so a max-length burst never wraps.
            if (state == S_AW && awready) begin
                beat_cnt <= '0;
            end else if (state == S_W && wready && !last_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            if (state != S_IDLE && state_nx == S_IDLE) ptr <= ptr_nx;
        end
    end

endmodule
